// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared types for the weighted round-robin burst arbiter.
// Holds the FSM state enum and the pointer wrap helper.
package wrr_burst_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int unsigned next_ptr(
    int unsigned o,
    int unsigned n
  );
    return (o == n - 1) ? 0 : o + 1;
  endfunction

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin selector: first requester at or after rr_i wins.
// Ports: rr_i start index, req_i/gnt_o per input, req_o/gnt_i/data_o/idx_o out.
module rr_arb_tree #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          ExtPrio   = 1'b1,
  parameter bit          FairArb   = 1'b0,
  parameter bit          AxiVldRdy = 1'b0,
  localparam int unsigned IdxWidth =
    (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic [IdxWidth-1:0]  rr_i,
  input  logic [NumIn-1:0]     req_i,
  output logic [NumIn-1:0]     gnt_o,
  input  logic [DataWidth-1:0] data_i [NumIn],
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [DataWidth-1:0] data_o,
  output logic [IdxWidth-1:0]  idx_o
);

  logic [IdxWidth-1:0] start;
  logic [IdxWidth-1:0] sel;
  logic                found;

  // Without an external or fair pointer the scan is fixed priority.
  assign start = (ExtPrio || FairArb) ? rr_i : '0;

  always_comb begin
    int unsigned k;
    logic [IdxWidth-1:0] kk;
    k     = 0;
    kk    = '0;
    sel   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      k  = (32'(start) + i) % NumIn;
      kk = IdxWidth'(k);
      if (!found && req_i[kk]) begin
        found = 1'b1;
        sel   = kk;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) begin
      gnt_o[sel] = AxiVldRdy ? gnt_i
                             : (gnt_i & req_i[sel]);
    end
  end

  assign req_o  = |req_i;
  assign data_o = data_i[sel];
  assign idx_o  = sel;

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter that locks the port for a whole burst.
// Ports: req_i/gnt_o/data_i/last_i up, req_o/gnt_i/data_o/last_o down, busy_o, err_o.
module wrr_burst_arbiter
  import wrr_burst_arbiter_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned MaxBeats    = 256,
  localparam int unsigned IdxWidth =
    (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0]   weight_i,
  input  logic [NumIn-1:0]                    req_i,
  output logic [NumIn-1:0]                    gnt_o,
  input  logic [DataWidth-1:0]                data_i [NumIn],
  input  logic [NumIn-1:0]                    last_i,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic [DataWidth-1:0]                data_o,
  output logic                                last_o,
  output logic [IdxWidth-1:0]                 idx_o,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned BeatWidth = $clog2(MaxBeats + 1);

  state_e                 state_q, state_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [IdxWidth-1:0]    owner_q, owner_d;
  logic [WeightWidth-1:0] cnt_q, cnt_d;
  logic [BeatWidth-1:0]   beat_q, beat_d;
  logic                   err_q, err_d;

  logic [NumIn-1:0]       arb_gnt;
  logic                   arb_req;
  logic [DataWidth-1:0]   arb_data;
  logic [IdxWidth-1:0]    arb_idx;

  logic                   hs;
  logic                   wdog;
  logic [WeightWidth:0]   cnt_inc;
  logic [WeightWidth:0]   quota;
  logic                   quota_done;
  logic [IdxWidth-1:0]    end_ptr;
  logic [WeightWidth-1:0] end_cnt;

  rr_arb_tree #(
    .NumIn     (NumIn),
    .DataWidth (DataWidth),
    .ExtPrio   (1'b1),
    .FairArb   (1'b0),
    .AxiVldRdy (1'b0)
  ) u_rr (
    .rr_i   (ptr_q),
    .req_i  (req_i),
    .gnt_o  (arb_gnt),
    .data_i (data_i),
    .req_o  (arb_req),
    .gnt_i  (gnt_i),
    .data_o (arb_data),
    .idx_o  (arb_idx)
  );

  always_comb begin
    req_o  = 1'b0;
    gnt_o  = '0;
    idx_o  = arb_idx;
    data_o = arb_data;
    if (state_q == BURST) begin
      idx_o  = owner_q;
      data_o = data_i[owner_q];
    end
    last_o = last_i[idx_o];
    if (!flush_i) begin
      if (state_q == BURST) begin
        req_o          = req_i[owner_q];
        gnt_o[owner_q] = gnt_i & req_i[owner_q];
      end else begin
        req_o = arb_req;
        gnt_o = arb_gnt;
      end
    end
  end

  assign hs   = req_o && gnt_i;
  assign wdog = (32'(beat_q) + 32'd1) == MaxBeats;

  // Burst-end accounting for the currently selected input.
  always_comb begin
    cnt_inc    = {1'b0, cnt_q} + (WeightWidth + 1)'(1);
    quota      = (weight_i[idx_o] == '0)
               ? (WeightWidth + 1)'(1)
               : {1'b0, weight_i[idx_o]};
    quota_done = cnt_inc >= quota;
    end_ptr    = quota_done
               ? IdxWidth'(next_ptr(32'(idx_o), NumIn))
               : idx_o;
    end_cnt    = quota_done ? '0 : cnt_inc[WeightWidth-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    owner_d = owner_q;
    err_d   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      beat_d  = '0;
      owner_d = '0;
    end else if (hs) begin
      unique case (state_q)
        IDLE: begin
          if (last_o) begin
            ptr_d = end_ptr;
            cnt_d = end_cnt;
          end else begin
            state_d = BURST;
            owner_d = idx_o;
            beat_d  = BeatWidth'(1);
          end
        end
        BURST: begin
          beat_d = beat_q + BeatWidth'(1);
          if (last_o || wdog) begin
            state_d = IDLE;
            beat_d  = '0;
            ptr_d   = end_ptr;
            cnt_d   = end_cnt;
            err_d   = !last_o;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q == BURST);
  assign err_o  = err_q;

endmodule
